// File: rtl/pll_lock_rst_seq_if.sv
// Control and status bundle between the PLL lock/reset sequencer (master) and
// the surrounding PLL wrapper and status logic (slave).
interface pll_lock_rst_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock_i;
    logic             relock_req_i;
    logic             pll_rst_o;
    logic             domain_rst_n_o;
    logic             locked_o;
    logic             fault_o;
    logic [CNT_W-1:0] lock_loss_cnt_o;
    logic [1:0]       state_o;

    modport master (
        input  pll_lock_i, relock_req_i,
        output pll_rst_o, domain_rst_n_o, locked_o, fault_o, lock_loss_cnt_o, state_o
    );

    modport slave (
        output pll_lock_i, relock_req_i,
        input  pll_rst_o, domain_rst_n_o, locked_o, fault_o, lock_loss_cnt_o, state_o
    );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock
// over a stability window, releases the clkout0 domain reset and retries on timeout.
module pll_lock_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pll_lock_rst_seq_if.master  bus
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'b00,
        WAIT_LOCK = 2'b01,
        RUN       = 2'b10,
        FAULT     = 2'b11
    } state_e;

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic [1:0]       sync_q;
    state_e           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             dom_rst_n_q, dom_rst_n_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic             lock_s;

    assign lock_s = sync_q[1];

    // NOTE: reset is synchronous (only sampled on a clk edge) and all state
    // uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= RESET_PLL;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            rty_q       <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.pll_lock_i};
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rty_q       <= rty_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_n_q <= dom_rst_n_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        rty_d     = rty_q;
        loss_d    = loss_q;
        if (bus.relock_req_i) begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
            stb_cnt_d = '0;
            tmo_cnt_d = '0;
            rty_d     = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = WAIT_LOCK;
                        rst_cnt_d = '0;
                        stb_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    stb_cnt_d = lock_s ? stb_cnt_q + STB_W'(1) : '0;
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    // Stability completion takes priority over a coincident timeout.
                    if (lock_s && stb_cnt_q == STB_LAST) begin
                        state_d   = RUN;
                        rty_d     = '0;
                        stb_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rty_d     = rty_q + RTY_W'(1);
                        state_d   = (rty_d == RTY_MAX) ? FAULT : RESET_PLL;
                        rst_cnt_d = '0;
                        stb_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d   = RESET_PLL;
                        rst_cnt_d = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + CNT_W'(1);
                        end
                    end
                end
                FAULT: ;
                default: state_d = RESET_PLL;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // together with state_q and never glitch on multi-bit state transitions.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        pll_rst_d   = 1'b0;
        dom_rst_n_d = 1'b0;
        locked_d    = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            RESET_PLL: pll_rst_d = 1'b1;
            RUN: begin
                dom_rst_n_d = 1'b1;
                locked_d    = 1'b1;
            end
            FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pll_rst_o       = pll_rst_q;
    assign bus.domain_rst_n_o  = dom_rst_n_q;
    assign bus.locked_o        = locked_q;
    assign bus.fault_o         = fault_q;
    assign bus.lock_loss_cnt_o = loss_q;
    assign bus.state_o         = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: two instances (default and shortened timing) compared
// every cycle against a cycle-counting reference model, plus directed timing checks.
module tb_pll_lock_rst_seq;

    localparam int A_RST = 16, A_STB = 1024, A_TMO = 100000, A_MR = 4, A_CW = 8;
    localparam int B_RST = 5,  B_STB = 40,   B_TMO = 200,    B_MR = 4, B_CW = 2;

    typedef struct packed {
        int mode;     // 0 reset pulse, 1 waiting, 2 running, 3 fault
        int elapsed;  // cycles spent in the current phase
        int high;     // consecutive synchronised-high cycles while waiting
        int retries;
        int losses;
        bit h1;
        bit h2;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_na, rst_nb;
    int   n_cmp = 0;
    int   n_bad = 0;
    mdl_t ma = '0;
    mdl_t mb = '0;

    always #5 clk = ~clk;

    pll_lock_rst_seq_if #(.CNT_W(A_CW)) ifa ();
    pll_lock_rst_seq_if #(.CNT_W(B_CW)) ifb ();

    pll_lock_rst_seq #(.RST_CYCLES(A_RST), .STABLE_CYCLES(A_STB), .LOCK_TIMEOUT(A_TMO),
                       .MAX_RETRIES(A_MR), .CNT_W(A_CW))
        dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));

    pll_lock_rst_seq #(.RST_CYCLES(B_RST), .STABLE_CYCLES(B_STB), .LOCK_TIMEOUT(B_TMO),
                       .MAX_RETRIES(B_MR), .CNT_W(B_CW))
        dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

    function automatic mdl_t step(mdl_t m, logic lock, logic relock, logic rstn,
                                  int rc, int sc, int tc, int mr, int cmax);
        mdl_t n;
        bit   lock_s;
        n = m;
        if (!rstn) return '0;
        lock_s = m.h2;
        n.h2 = m.h1;
        n.h1 = lock;
        if (relock) begin
            n.mode = 0; n.elapsed = 0; n.high = 0; n.retries = 0;
        end else begin
            case (m.mode)
                0: begin
                    n.elapsed = m.elapsed + 1;
                    if (n.elapsed == rc) begin n.mode = 1; n.elapsed = 0; n.high = 0; end
                end
                1: begin
                    n.elapsed = m.elapsed + 1;
                    n.high = lock_s ? m.high + 1 : 0;
                    if (n.high == sc) begin
                        n.mode = 2; n.retries = 0;
                    end else if (n.elapsed == tc) begin
                        n.retries = m.retries + 1;
                        n.mode = (n.retries == mr) ? 3 : 0;
                        n.elapsed = 0;
                    end
                end
                2: if (!lock_s) begin
                    n.mode = 0; n.elapsed = 0;
                    n.losses = (m.losses < cmax) ? m.losses + 1 : cmax;
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    // {pll_rst, domain_rst_n, locked, fault, state[1:0], count[7:0]}
    function automatic logic [13:0] expv(mdl_t m);
        logic pr, dn, ft;
        pr = (m.mode == 0) || (m.mode == 3);
        dn = (m.mode == 2);
        ft = (m.mode == 3);
        return {pr, dn, dn, ft, 2'(m.mode), 8'(m.losses)};
    endfunction

    function automatic logic [13:0] obs_a();
        return {ifa.pll_rst_o, ifa.domain_rst_n_o, ifa.locked_o, ifa.fault_o,
                ifa.state_o, ifa.lock_loss_cnt_o};
    endfunction

    function automatic logic [13:0] obs_b();
        return {ifb.pll_rst_o, ifb.domain_rst_n_o, ifb.locked_o, ifb.fault_o,
                ifb.state_o, 6'd0, ifb.lock_loss_cnt_o};
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, ifa.pll_lock_i, ifa.relock_req_i, rst_na, A_RST, A_STB, A_TMO, A_MR, 255);
        mb <= step(mb, ifb.pll_lock_i, ifb.relock_req_i, rst_nb, B_RST, B_STB, B_TMO, B_MR, 3);
    end

    task automatic test_reset();
        int first_low = -1;
        int first_run = -1;
        ifa.pll_lock_i = 1'b1;
        rst_na = 1'b0;
        repeat (3) @(negedge clk);
        if (obs_a() !== 14'h2000) begin
            n_bad++; $display("FAIL reset_values got %h want %h", obs_a(), 14'h2000);
        end
        n_cmp++;
        rst_na = 1'b1;
        for (int n = 1; n <= A_RST + A_STB + 20; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL reset_model n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
            if (first_low < 0 && ifa.pll_rst_o === 1'b0) first_low = n;
            if (first_run < 0 && ifa.state_o === 2'b10) begin
                first_run = n;
                if ({ifa.domain_rst_n_o, ifa.locked_o} !== 2'b11) begin
                    n_bad++; $display("FAIL reset_release got %b want 11",
                                      {ifa.domain_rst_n_o, ifa.locked_o});
                end
                n_cmp++;
            end
        end
        if (first_low != A_RST) begin
            n_bad++; $display("FAIL reset_pulse_len got %0d want %0d", first_low, A_RST);
        end
        n_cmp++;
        if (first_run != A_RST + A_STB) begin
            n_bad++; $display("FAIL reset_run_edge got %0d want %0d", first_run, A_RST + A_STB);
        end
        n_cmp++;
    endtask

    task automatic test_lock_glitch();
        int run_at = -1;
        ifa.pll_lock_i = 1'b0;
        rst_na = 1'b0;
        @(negedge clk);
        rst_na = 1'b1;
        for (int n = 1; n <= A_RST + 10 + 500 + 1; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL glitch_model n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
            if (n == A_RST + 10) ifa.pll_lock_i = 1'b1;
            if (n == A_RST + 10 + 500) ifa.pll_lock_i = 1'b0;
        end
        ifa.pll_lock_i = 1'b1;
        for (int n = 1; n <= A_STB + 50 && run_at < 0; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL glitch_model2 n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
            if (ifa.state_o === 2'b10) run_at = n;
        end
        if (run_at != A_STB + 2) begin
            n_bad++; $display("FAIL glitch_run_edge got %0d want %0d", run_at, A_STB + 2);
        end
        n_cmp++;
    endtask

    task automatic test_lock_drop();
        int fall_at = -1;
        int rerun = -1;
        ifa.pll_lock_i = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL drop_model n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
            if (fall_at < 0 && ifa.domain_rst_n_o === 1'b0) fall_at = n;
            if (n == 3) ifa.pll_lock_i = 1'b1;
        end
        if (fall_at != 3) begin
            n_bad++; $display("FAIL drop_latency got %0d want 3", fall_at);
        end
        n_cmp++;
        if (ifa.lock_loss_cnt_o !== 8'd1) begin
            n_bad++; $display("FAIL drop_count got %0d want 1", ifa.lock_loss_cnt_o);
        end
        n_cmp++;
        for (int n = 1; n <= A_RST + A_STB + 20 && rerun < 0; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL drop_model2 n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
            if (ifa.state_o === 2'b10) rerun = n;
        end
        if (rerun < 0) begin
            n_bad++; $display("FAIL drop_rerun got no RUN within %0d cycles", A_RST + A_STB + 20);
        end
        n_cmp++;
    endtask

    task automatic test_relock_vs_drop();
        ifa.pll_lock_i = 1'b0;
        @(negedge clk);
        ifa.pll_lock_i = 1'b1;
        @(negedge clk);
        ifa.relock_req_i = 1'b1;
        @(negedge clk);
        ifa.relock_req_i = 1'b0;
        if ({ifa.state_o, ifa.lock_loss_cnt_o} !== {2'b00, 8'd1}) begin
            n_bad++; $display("FAIL relock_drop got state %b cnt %0d want state 00 cnt 1",
                              ifa.state_o, ifa.lock_loss_cnt_o);
        end
        n_cmp++;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL relock_model n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
        end
    endtask

    task automatic test_rst_pulse();
        int first_low = -1;
        ifa.pll_lock_i = 1'b0;
        for (int n = 1; n <= A_RST + 100; n++) begin
            @(negedge clk);
            if (obs_a() !== expv(ma)) begin
                n_bad++; $display("FAIL rstpulse_model n=%0d got %h want %h", n, obs_a(), expv(ma));
            end
            n_cmp++;
        end
        if (ifa.state_o !== 2'b01) begin
            n_bad++; $display("FAIL rstpulse_pre_state got %b want 01", ifa.state_o);
        end
        n_cmp++;
        rst_na = 1'b0;
        @(negedge clk);
        rst_na = 1'b1;
        if (obs_a() !== 14'h2000) begin
            n_bad++; $display("FAIL rstpulse_values got %h want %h", obs_a(), 14'h2000);
        end
        n_cmp++;
        for (int n = 1; n <= A_RST + 5; n++) begin
            @(negedge clk);
            if (first_low < 0 && ifa.pll_rst_o === 1'b0) first_low = n;
        end
        if (first_low != A_RST) begin
            n_bad++; $display("FAIL rstpulse_restart got %0d want %0d", first_low, A_RST);
        end
        n_cmp++;
    endtask

    task automatic test_timeout_fault();
        int   fault_at = -1;
        int   waits = 0;
        logic prev_wait = 1'b0;
        ifb.pll_lock_i = 1'b0;
        rst_nb = 1'b0;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int n = 1; n <= B_MR * (B_RST + B_TMO) + 50 && fault_at < 0; n++) begin
            @(negedge clk);
            if (obs_b() !== expv(mb)) begin
                n_bad++; $display("FAIL timeout_model n=%0d got %h want %h", n, obs_b(), expv(mb));
            end
            n_cmp++;
            if (ifb.state_o === 2'b01 && !prev_wait) waits++;
            prev_wait = (ifb.state_o === 2'b01);
            if (ifb.fault_o === 1'b1) fault_at = n;
        end
        if (fault_at != B_MR * (B_RST + B_TMO)) begin
            n_bad++; $display("FAIL timeout_fault_edge got %0d want %0d", fault_at, B_MR * (B_RST + B_TMO));
        end
        n_cmp++;
        if (waits != B_MR) begin
            n_bad++; $display("FAIL timeout_wait_entries got %0d want %0d", waits, B_MR);
        end
        n_cmp++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (obs_b() !== expv(mb)) begin
                n_bad++; $display("FAIL fault_hold n=%0d got %h want %h", n, obs_b(), expv(mb));
            end
            n_cmp++;
        end
        if ({ifb.pll_rst_o, ifb.fault_o, ifb.state_o} !== 4'b1111) begin
            n_bad++; $display("FAIL fault_outputs got %b want 1111",
                              {ifb.pll_rst_o, ifb.fault_o, ifb.state_o});
        end
        n_cmp++;
        ifb.relock_req_i = 1'b1;
        @(negedge clk);
        ifb.relock_req_i = 1'b0;
        if ({ifb.fault_o, ifb.state_o} !== 3'b000) begin
            n_bad++; $display("FAIL fault_relock got %b want 000", {ifb.fault_o, ifb.state_o});
        end
        n_cmp++;
    endtask

    task automatic test_saturate();
        ifb.pll_lock_i = 1'b1;
        rst_nb = 1'b0;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            int run_at = -1;
            for (int n = 1; n <= 80 && run_at < 0; n++) begin
                @(negedge clk);
                if (obs_b() !== expv(mb)) begin
                    n_bad++; $display("FAIL sat_model d=%0d got %h want %h", d, obs_b(), expv(mb));
                end
                n_cmp++;
                if (ifb.state_o === 2'b10) run_at = n;
            end
            if (run_at < 0) begin
                n_bad++; $display("FAIL sat_run d=%0d got no RUN within 80 cycles", d);
            end
            n_cmp++;
            ifb.pll_lock_i = 1'b0;
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                if (n == 3) ifb.pll_lock_i = 1'b1;
            end
            if (ifb.lock_loss_cnt_o !== 2'((d < 3) ? d : 3)) begin
                n_bad++; $display("FAIL sat_count d=%0d got %0d want %0d",
                                  d, ifb.lock_loss_cnt_o, (d < 3) ? d : 3);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        rst_nb = 1'b0;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int blk = 0; blk < 20; blk++) begin
            int mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 150; i++) begin
                case (mode)
                    0: ifb.pll_lock_i = 1'b1;
                    1: ifb.pll_lock_i = ($urandom_range(0, 99) < 70);
                    default: ifb.pll_lock_i = 1'b0;
                endcase
                ifb.relock_req_i = ($urandom_range(0, 399) == 0);
                rst_nb = ($urandom_range(0, 799) != 0);
                @(negedge clk);
                if (obs_b() !== expv(mb)) begin
                    n_bad++; $display("FAIL random_model blk=%0d i=%0d got %h want %h",
                                      blk, i, obs_b(), expv(mb));
                end
                n_cmp++;
            end
        end
        rst_nb = 1'b1;
        ifb.relock_req_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        ifa.pll_lock_i = 1'b0;
        ifa.relock_req_i = 1'b0;
        ifb.pll_lock_i = 1'b0;
        ifb.relock_req_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lock_glitch();
        test_lock_drop();
        test_relock_vs_drop();
        test_rst_pulse();
        test_timeout_fault();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
